// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - frame load bus and multiplexed display bus of the scan controller.
interface seg_scan_ctrl_if;
    logic        i_load;
    logic [23:0] i_digits;
    logic [5:0]  i_dp;
    logic [5:0]  i_blank;
    logic [5:0]  i_blink;
    logic [6:0]  o_seg;
    logic        o_seg_dp;
    logic [5:0]  o_seg_enb;
    logic        o_frame;
    logic        o_pend;

    modport master (
        output i_load, i_digits, i_dp, i_blank, i_blink,
        input  o_seg, o_seg_dp, o_seg_enb, o_frame, o_pend
    );

    modport slave (
        input  i_load, i_digits, i_dp, i_blank, i_blink,
        output o_seg, o_seg_dp, o_seg_enb, o_frame, o_pend
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - six-digit seven-segment scan controller with tear-free double-buffered frames.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250
) (
    input logic           clk,
    input logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic          pend_q, pend_d;

    logic [23:0] sh_digits_q, sh_digits_d, act_digits_q, act_digits_d;
    logic [5:0]  sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [5:0]  sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [5:0]  sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;

    logic [6:0] seg_q, seg_d;
    logic       seg_dp_q, seg_dp_d;
    logic [5:0] seg_enb_q, seg_enb_d;
    logic       frame_q, frame_d;

    logic       tick;
    logic       wrap;
    logic       dark;
    logic [3:0] code;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        wrap  = tick && (idx_q == 3'd5);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        blk_cnt_d  = blk_cnt_q;
        blink_ph_d = blink_ph_q;
        if (tick) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d  = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BW'(1);
            end
        end

        // The frame applied at a wrap is the shadow as it stood before this edge,
        // so a coincident load is kept pending for the following frame.
        act_digits_d = act_digits_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        act_blink_d  = act_blink_q;
        if (wrap && pend_q) begin
            act_digits_d = sh_digits_q;
            act_dp_d     = sh_dp_q;
            act_blank_d  = sh_blank_q;
            act_blink_d  = sh_blink_q;
        end

        sh_digits_d = sh_digits_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        sh_blink_d  = sh_blink_q;
        if (bus.i_load) begin
            sh_digits_d = bus.i_digits;
            sh_dp_d     = bus.i_dp;
            sh_blank_d  = bus.i_blank;
            sh_blink_d  = bus.i_blink;
        end
        pend_d = bus.i_load | (pend_q & ~wrap);

        code      = act_digits_d[{idx_d, 2'b00} +: 4];
        dark      = act_blank_d[idx_d] | (act_blink_d[idx_d] & blink_ph_d);
        seg_d     = dark ? 7'd0 : hex7(code);
        seg_dp_d  = ~dark & act_dp_d[idx_d];
        seg_enb_d = 6'b000001 << idx_d;
        frame_d   = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            blk_cnt_q    <= '0;
            blink_ph_q   <= 1'b0;
            pend_q       <= 1'b0;
            sh_digits_q  <= 24'd0;
            sh_dp_q      <= 6'd0;
            sh_blank_q   <= 6'd0;
            sh_blink_q   <= 6'd0;
            act_digits_q <= 24'd0;
            act_dp_q     <= 6'd0;
            act_blank_q  <= 6'b111111;
            act_blink_q  <= 6'd0;
            seg_q        <= 7'd0;
            seg_dp_q     <= 1'b0;
            seg_enb_q    <= 6'b000001;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            blk_cnt_q    <= blk_cnt_d;
            blink_ph_q   <= blink_ph_d;
            pend_q       <= pend_d;
            sh_digits_q  <= sh_digits_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            sh_blink_q   <= sh_blink_d;
            act_digits_q <= act_digits_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_blink_q  <= act_blink_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            seg_enb_q    <= seg_enb_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.o_seg     = seg_q;
    assign bus.o_seg_dp  = seg_dp_q;
    assign bus.o_seg_enb = seg_enb_q;
    assign bus.o_frame   = frame_q;
    assign bus.o_pend    = pend_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard testbench for seg_scan_ctrl.
module tb_seg_scan_ctrl;
    localparam int SCAN  = 4;
    localparam int BLINK = 2;
    localparam int FRAME = 6 * SCAN;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [15:0] obs;
    assign obs = {bus.o_seg, bus.o_seg_dp, bus.o_seg_enb, bus.o_frame, bus.o_pend};

    logic [6:0] seg_tab [0:15];

    // Timeline model: position in the scan is derived from cycles since reset.
    int          m_t;
    logic [23:0] ma_dig, ms_dig;
    logic [5:0]  ma_dp, ms_dp, ma_blank, ms_blank, ma_blink, ms_blink;
    logic        m_pend;

    always @(posedge clk) begin : model
        int   idx;
        logic ph;
        logic dark;
        logic [3:0] code;
        if (rst) begin
            m_t = 0;
            ma_dig = '0; ma_dp = '0; ma_blank = '1; ma_blink = '0;
            ms_dig = '0; ms_dp = '0; ms_blank = '0; ms_blink = '0;
            m_pend = 1'b0;
        end else begin
            m_t++;
            if ((m_t % FRAME) == 0 && m_pend) begin
                ma_dig = ms_dig; ma_dp = ms_dp; ma_blank = ms_blank; ma_blink = ms_blink;
                m_pend = 1'b0;
            end
            if (bus.i_load) begin
                ms_dig = bus.i_digits; ms_dp = bus.i_dp;
                ms_blank = bus.i_blank; ms_blink = bus.i_blink;
                m_pend = 1'b1;
            end
        end
        idx  = (m_t / SCAN) % 6;
        ph   = (((m_t / SCAN) / BLINK) % 2) == 1;
        dark = ma_blank[idx] || (ma_blink[idx] && ph);
        code = ma_dig[idx*4 +: 4];
        exp_q.push_back({dark ? 7'd0 : seg_tab[code], ~dark & ma_dp[idx], 6'(1 << idx),
                         (m_t > 0) && ((m_t % FRAME) == 0), m_pend});
    end

    task automatic cyc();
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0d", m_t);
            exp_v = 'x;
        end else begin
            exp_v = exp_q.pop_front();
        end
    endtask

    task automatic load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl, input logic [5:0] bk);
        bus.i_load = 1'b1; bus.i_digits = d; bus.i_dp = dp; bus.i_blank = bl; bus.i_blink = bk;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            cyc();
            checks++;
            if (obs !== 16'h0004) begin
                errors++;
                $display("FAIL reset_value got %h exp %h", obs, 16'h0004);
            end
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_model got %h exp %h", obs, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan_dark();
        int frames = 0;
        repeat (30) begin
            cyc();
            if (bus.o_frame === 1'b1) frames++;
            checks++;
            if (obs !== exp_v || bus.o_seg !== 7'd0) begin
                errors++;
                $display("FAIL scan_dark t=%0d got %h exp %h", m_t, obs, exp_v);
            end
        end
        checks++;
        if (frames != 1) begin
            errors++;
            $display("FAIL scan_frame_count got %0d exp 1", frames);
        end
    endtask

    task automatic test_load_decode();
        bit applied = 0;
        load(24'hF83210, 6'b000001, 6'b000000, 6'b000000);
        cyc();
        bus.i_load = 1'b0;
        checks++;
        if (bus.o_pend !== 1'b1 || obs !== exp_v) begin
            errors++;
            $display("FAIL load_pend_rise got %h exp %h", obs, exp_v);
        end
        repeat (2 * FRAME) begin
            cyc();
            if (bus.o_frame === 1'b1) applied = 1;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_model t=%0d got %h exp %h", m_t, obs, exp_v);
            end
            checks++;
            if (!applied && bus.o_pend !== 1'b1) begin
                errors++;
                $display("FAIL load_pend_hold got %b exp 1", bus.o_pend);
            end else if (applied && bus.o_seg_enb === 6'b000001 &&
                         ({bus.o_seg, bus.o_seg_dp, bus.o_pend} !== {7'b1111110, 1'b1, 1'b0})) begin
                errors++;
                $display("FAIL decode_digit0 got %b/%b exp 1111110/1", bus.o_seg, bus.o_seg_dp);
            end else if (applied && bus.o_seg_enb === 6'b000010 && bus.o_seg !== 7'b0110000) begin
                errors++;
                $display("FAIL decode_digit1 got %b exp 0110000", bus.o_seg);
            end else if (applied && bus.o_seg_enb === 6'b100000 && bus.o_seg !== 7'b1000111) begin
                errors++;
                $display("FAIL decode_digit5 got %b exp 1000111", bus.o_seg);
            end
        end
        checks++;
        if (!applied) begin
            errors++;
            $display("FAIL load_applied got 0 exp 1");
        end
    endtask

    task automatic test_latest_wins();
        load(24'hF83211, 6'b000000, 6'b000000, 6'b000000);
        cyc();
        bus.i_load = 1'b0;
        repeat (3) cyc();
        load(24'hF83218, 6'b000000, 6'b000000, 6'b000000);
        cyc();
        bus.i_load = 1'b0;
        repeat (2 * FRAME) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL latest_model t=%0d got %h exp %h", m_t, obs, exp_v);
            end
            checks++;
            if (bus.o_seg_enb === 6'b000001 && bus.o_seg === 7'b0110000) begin
                errors++;
                $display("FAIL latest_stale got %b exp 1111111", bus.o_seg);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        if ((m_t % FRAME) == FRAME - 1) cyc();
        load(24'h000005, 6'b000000, 6'b000000, 6'b000000);
        cyc();
        bus.i_load = 1'b0;
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) cyc();
        load(24'h000007, 6'b000000, 6'b000000, 6'b000000);
        cyc();
        bus.i_load = 1'b0;
        checks++;
        if ({bus.o_frame, bus.o_pend, bus.o_seg} !== {1'b1, 1'b1, 7'b1011011} || obs !== exp_v) begin
            errors++;
            $display("FAIL wrap_load_apply got %h exp frame=1 pend=1 seg=1011011 model %h", obs, exp_v);
        end
        repeat (FRAME) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL wrap_load_model t=%0d got %h exp %h", m_t, obs, exp_v);
            end
        end
        checks++;
        if ({bus.o_frame, bus.o_pend, bus.o_seg} !== {1'b1, 1'b0, 7'b1110000}) begin
            errors++;
            $display("FAIL wrap_load_next got %b/%b/%b exp 1/0/1110000", bus.o_frame, bus.o_pend, bus.o_seg);
        end
    endtask

    task automatic test_blink();
        bit seen_lit = 0;
        bit seen_dark = 0;
        load(24'h888888, 6'b000000, 6'b000000, 6'b000001);
        cyc();
        bus.i_load = 1'b0;
        for (int i = 0; i < FRAME && bus.o_frame !== 1'b1; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL blink_pre t=%0d got %h exp %h", m_t, obs, exp_v);
            end
        end
        repeat (3 * FRAME) begin
            cyc();
            if (bus.o_seg_enb === 6'b000001) begin
                if (bus.o_seg === 7'b1111111) seen_lit = 1;
                if (bus.o_seg === 7'd0) seen_dark = 1;
            end
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL blink_model t=%0d got %h exp %h", m_t, obs, exp_v);
            end
            checks++;
            if (bus.o_seg_enb !== 6'b000001 && bus.o_seg !== 7'b1111111) begin
                errors++;
                $display("FAIL blink_other got %b exp 1111111", bus.o_seg);
            end
        end
        checks++;
        if (!(seen_lit && seen_dark)) begin
            errors++;
            $display("FAIL blink_toggle got lit=%0b dark=%0b exp 1/1", seen_lit, seen_dark);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FRAME && bus.o_seg === 7'd0; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (obs !== 16'h0004 || obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid got %h exp %h", obs, 16'h0004);
        end
        repeat (40) begin
            cyc();
            checks++;
            if (obs !== exp_v || bus.o_seg !== 7'd0 || bus.o_pend !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_dark t=%0d got %h exp %h", m_t, obs, exp_v);
            end
        end
    endtask

    initial begin
        seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000; seg_tab[2]  = 7'b1101101;
        seg_tab[3]  = 7'b1111001; seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
        seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000; seg_tab[8]  = 7'b1111111;
        seg_tab[9]  = 7'b1111011; seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b0011111;
        seg_tab[12] = 7'b1001110; seg_tab[13] = 7'b0111101; seg_tab[14] = 7'b1001111;
        seg_tab[15] = 7'b1000111;
        bus.i_load = 1'b0; bus.i_digits = '0; bus.i_dp = '0; bus.i_blank = '0; bus.i_blink = '0;
        test_reset();
        test_scan_dark();
        test_load_decode();
        test_latest_wins();
        test_load_on_wrap();
        test_blink();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the six-digit seven-segment display on the NCO/counter/display top level. It takes a six-digit frame from the counter datapath and time-multiplexes it onto the shared segment bus. A one-hot digit enable advances at a divided scan rate. New frames are double-buffered and swapped only at frame boundaries, so the display never tears. The block also supports per-digit blanking, blinking and decimal points.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz slot rate at 50 MHz); legal range ≥ 2.
- BLINK_DIV, 250: scan ticks per blink half-period; legal range ≥ 1.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; synchronous, active-high.
- i_load  in  1  one-cycle strobe; captures i_digits/i_dp/i_blank/i_blink into the shadow frame.
- i_digits  in  24  six 4-bit hex codes; digit k = i_digits[4k+3:4k].
- i_dp  in  6  decimal point per digit, 1 = lit.
- i_blank  in  6  per-digit blank mask, 1 = dark.
- i_blink  in  6  per-digit blink mask, 1 = blink.
- o_seg  out  7  segments {a,b,c,d,e,f,g}, active-high.
- o_seg_dp  out  1  decimal point of the current digit, active-high.
- o_seg_enb  out  6  one-hot digit enable, active-high; bit k = digit k.
- o_frame  out  1  one-cycle pulse when digit 0 of a frame begins.
- o_pend  out  1  shadow frame holds data not yet applied.

## Operation
- Tick counter cnt runs 0..SCAN_DIV-1 and wraps to 0. tick = (cnt == SCAN_DIV-1). Width is $clog2(SCAN_DIV).
- Digit index idx, 0..5, advances on tick; 5 wraps to 0 (frame wrap).
- Blink: a counter of ticks toggles blink_ph every BLINK_DIV ticks.
- Frame registers: an active set and a shadow set (digits, dp, blank, blink).
  - i_load writes the shadow set and sets pend. Latest load wins; a load while pend is already set overwrites the shadow.
  - On frame wrap with pend = 1: the shadow is copied to the active set and pend clears.
  - If i_load coincides with a frame wrap, the frame being applied is the shadow content held before that edge. The new load lands in the shadow and pend stays 1.
- Digit dark condition: active blank[idx] = 1, or (active blink[idx] = 1 and blink_ph = 1).
  - When dark: o_seg = 0 and o_seg_dp = 0. o_seg_enb is still driven.
- Decode (hex 0..F, standard patterns). Examples: 0 → 1111110, 1 → 0110000, 8 → 1111111, A → 1110111, F → 1000111.
- All outputs are registers, updated on the same edge as idx/cnt from next-state values. o_seg_enb always equals 1 << idx.

## Timing
- Reset values: cnt = 0, idx = 0, blink_ph = 0, pend = 0, shadow = 0.
  - Active set: digits = 0, dp = 0, blink = 0, blank = 6'b111111, so the display is dark until the first frame is applied.
  - Outputs in reset: o_seg = 0, o_seg_dp = 0, o_seg_enb = 6'b000001, o_frame = 0, o_pend = 0.
- Reset is synchronous and overrides everything. A reset mid-frame discards both the active and shadow frames.
- Digit dwell is exactly SCAN_DIV cycles. The frame period is 6·SCAN_DIV cycles.
- o_frame is high for exactly the one cycle in which o_seg_enb first shows 000001 after a wrap. It does not pulse out of reset.
- o_pend rises on the cycle after the i_load edge. It falls on the same edge at which the new frame's digit 0 appears on the outputs.
- Load-to-display latency: from 1 cycle (load just before a wrap tick) up to 6·SCAN_DIV cycles.
- blink_ph toggles on the edge of every BLINK_DIV-th tick. Its effect appears on that same edge.

## Test plan
- Reset, then run 30 cycles with SCAN_DIV = 4. Required: o_seg_enb steps 000001 → 000010 → … → 100000 → 000001 every 4 cycles; o_seg = 0 throughout (active blank = 111111); o_frame pulses at cycles 24, 48, …
- i_load with digits 5..0 = {F, 8, 3, 2, 1, 0}, dp = 000001, blank = 0. Required: o_pend = 1 until the next wrap. Then digit 0 shows o_seg = 1111110 with o_seg_dp = 1, digit 1 shows 0110000, digit 5 shows 1000111.
- Two loads (digit 0 = 1, then digit 0 = 8) within one frame. Required: only 8 appears (o_seg = 1111111 on digit 0). The value 1 is never displayed.
- i_load asserted on the wrap edge. Required: the previously pending frame is applied, o_pend stays 1, and the new data appears one frame later.
- BLINK_DIV = 2, blink = 000001. Required: digit 0 segments alternate between lit and 0 every 2 ticks; the other digits are unaffected; o_seg_enb is unchanged.
- Assert rst mid-frame with digits showing. Required: the next cycle shows the reset values; after rst is released, the display stays dark until a new load and wrap.
